// File: rtl/game_pkg.sv
// Shared types and default timing for the game step scheduler and its bench.
package game_pkg;

    typedef enum logic [1:0] {
        MODE_START  = 2'd0,
        MODE_GAME   = 2'd1,
        MODE_P1_WIN = 2'd2,
        MODE_P2_WIN = 2'd3
    } game_mode;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COUNTDOWN  = 3'd1,
        WAIT_FRAME = 3'd2,
        MOVE       = 3'd3,
        COLLIDE    = 3'd4
    } sched_state_t;

    localparam int unsigned STEP_FRAMES_DEF     = 4;
    localparam int unsigned COUNTDOWN_STEPS_DEF = 3;
    localparam int unsigned ACK_TIMEOUT_DEF     = 1023;
    localparam int unsigned STEP_CNT_W          = 16;

endpackage

// File: rtl/step_frame_counter.sv
// Counts frame_start pulses; due_c marks the pulse that completes a STEP_FRAMES period.
module step_frame_counter #(
    parameter int unsigned STEP_FRAMES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic frame_start_i,
    output logic due_c
);

    localparam int unsigned CW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign due_c = frame_start_i && !clear_i && (cnt_q == CW'(STEP_FRAMES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (frame_start_i) begin
            cnt_d = due_c ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/game_step_scheduler.sv
// Paces game steps on video frames: countdown, player move handshake, collision handshake,
// with overrun tracking and an ack watchdog.
module game_step_scheduler
    import game_pkg::*;
#(
    parameter int unsigned STEP_FRAMES     = STEP_FRAMES_DEF,
    parameter int unsigned COUNTDOWN_STEPS = COUNTDOWN_STEPS_DEF,
    parameter int unsigned ACK_TIMEOUT     = ACK_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  game_mode              mode,
    input  logic                  frame_start,
    output logic [1:0]            move_req,
    input  logic [1:0]            move_ack,
    output logic                  coll_req,
    input  logic                  coll_ack,
    output logic [2:0]            countdown,
    output logic [STEP_CNT_W-1:0] step_cnt,
    output logic                  active,
    output logic                  overrun,
    output logic                  timeout_err
);

    localparam int unsigned WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    sched_state_t          state_q, state_d;
    logic [1:0]            move_req_q, move_req_d;
    logic [1:0]            acked_q, acked_d;
    logic                  coll_req_q, coll_req_d;
    logic [2:0]            countdown_q, countdown_d;
    logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic                  active_q, active_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_q, timeout_d;
    logic                  pending_q, pending_d;
    logic [WW-1:0]         wd_q, wd_d;

    logic                  in_game;
    logic                  due;
    logic [1:0]            ack_hit;
    logic                  wd_expired;

    assign in_game    = (mode == MODE_GAME);
    assign ack_hit    = acked_q | (move_ack & move_req_q);
    assign wd_expired = (wd_q == WW'(ACK_TIMEOUT - 1));

    step_frame_counter #(
        .STEP_FRAMES (STEP_FRAMES)
    ) u_frame_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear_i       ((state_q == IDLE) || !in_game),
        .frame_start_i (frame_start),
        .due_c         (due)
    );

    // Next-state and output decode; leaving GAME overrides everything except the score.
    always_comb begin
        state_d     = state_q;
        move_req_d  = move_req_q;
        acked_d     = acked_q;
        coll_req_d  = coll_req_q;
        countdown_d = countdown_q;
        step_cnt_d  = step_cnt_q;
        pending_d   = pending_q;
        overrun_d   = 1'b0;
        timeout_d   = 1'b0;
        wd_d        = ((state_q == MOVE) || (state_q == COLLIDE)) ? wd_q + WW'(1) : wd_q;

        if (!in_game) begin
            state_d     = IDLE;
            move_req_d  = 2'b00;
            coll_req_d  = 1'b0;
            countdown_d = 3'd0;
            pending_d   = 1'b0;
            acked_d     = 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = COUNTDOWN;
                    countdown_d = 3'(COUNTDOWN_STEPS);
                    step_cnt_d  = '0;
                end
                COUNTDOWN: begin
                    if (due) begin
                        countdown_d = countdown_q - 3'd1;
                        if (countdown_q == 3'd1) state_d = WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (pending_q || due) begin
                        state_d    = MOVE;
                        pending_d  = 1'b0;
                        move_req_d = 2'b11;
                        acked_d    = 2'b00;
                        wd_d       = '0;
                    end
                end
                MOVE, COLLIDE: begin
                    // A step falling due while busy is remembered once, flagged every time.
                    if (due) begin
                        pending_d = 1'b1;
                        overrun_d = 1'b1;
                    end
                    if (wd_expired) begin
                        timeout_d  = 1'b1;
                        move_req_d = 2'b00;
                        coll_req_d = 1'b0;
                        acked_d    = 2'b00;
                        state_d    = WAIT_FRAME;
                    end else if (state_q == MOVE) begin
                        if (ack_hit == 2'b11) begin
                            state_d    = COLLIDE;
                            acked_d    = 2'b00;
                            move_req_d = 2'b00;
                            coll_req_d = 1'b1;
                        end else begin
                            acked_d    = ack_hit;
                            move_req_d = ~ack_hit;
                        end
                    end else if (coll_ack) begin
                        coll_req_d = 1'b0;
                        state_d    = WAIT_FRAME;
                        if (step_cnt_q != '1) step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        active_d = (state_d == WAIT_FRAME) || (state_d == MOVE) || (state_d == COLLIDE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            move_req_q  <= 2'b00;
            acked_q     <= 2'b00;
            coll_req_q  <= 1'b0;
            countdown_q <= 3'd0;
            step_cnt_q  <= '0;
            active_q    <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            pending_q   <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            move_req_q  <= move_req_d;
            acked_q     <= acked_d;
            coll_req_q  <= coll_req_d;
            countdown_q <= countdown_d;
            step_cnt_q  <= step_cnt_d;
            active_q    <= active_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            pending_q   <= pending_d;
            wd_q        <= wd_d;
        end
    end

    assign move_req    = move_req_q;
    assign coll_req    = coll_req_q;
    assign countdown   = countdown_q;
    assign step_cnt    = step_cnt_q;
    assign active      = active_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_game_step_scheduler.sv
// Directed scenarios with randomized gaps and ack orders against a step/handshake model.
module tb_game_step_scheduler;
    import game_pkg::*;

    logic       clk;
    logic       rst;
    game_mode   mode;
    logic       frame_start;
    logic [1:0] move_req;
    logic [1:0] move_ack;
    logic       coll_req;
    logic       coll_ack;
    logic [2:0] countdown;
    logic [15:0] step_cnt;
    logic       active;
    logic       overrun;
    logic       timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    game_step_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .frame_start (frame_start),
        .move_req    (move_req),
        .move_ack    (move_ack),
        .coll_req    (coll_req),
        .coll_ack    (coll_ack),
        .countdown   (countdown),
        .step_cnt    (step_cnt),
        .active      (active),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge, pulses dropped there.
    task automatic cyc();
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        move_ack    = 2'b00;
        coll_ack    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        cyc();
    endtask

    initial begin
        int  exp_steps;
        int  cd_exp;
        int  d1, d2, dc, c;
        logic [1:0] acked;
        logic [1:0] a;
        logic bad;
        logic [15:0] held;

        rst = 1'b1; mode = MODE_START; frame_start = 1'b0; move_ack = 2'b00; coll_ack = 1'b0;
        exp_steps = 0;
        idle(3);
        rst = 1'b0;
        cyc();
        chk("reset_move_req", 32'(move_req), 0);
        chk("reset_coll_req", 32'(coll_req), 0);
        chk("reset_countdown", 32'(countdown), 0);
        chk("reset_step_cnt", 32'(step_cnt), 0);
        chk("reset_active", 32'(active), 0);
        chk("reset_pulses", 32'({overrun, timeout_err}), 0);

        // Frames outside GAME must not start anything.
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            frame();
            if (move_req != 0 || coll_req || active || countdown != 0) bad = 1'b1;
            idle($urandom_range(0, 2));
        end
        chk("start_mode_quiet", 32'(bad), 0);

        // Countdown 3,2,1 then first step on the 16th frame overall.
        mode = MODE_GAME;
        cyc();
        chk("cd_initial", 32'(countdown), COUNTDOWN_STEPS_DEF);
        chk("cd_active", 32'(active), 0);
        for (int k = 1; k <= 16; k++) begin
            idle($urandom_range(0, 3));
            frame();
            cd_exp = (k >= int'(COUNTDOWN_STEPS_DEF * STEP_FRAMES_DEF)) ? 0
                   : int'(COUNTDOWN_STEPS_DEF) - k / int'(STEP_FRAMES_DEF);
            chk($sformatf("cd_after_frame%0d", k), 32'(countdown), 32'(cd_exp));
            chk($sformatf("move_req_frame%0d", k), 32'(move_req), (k == 16) ? 3 : 0);
        end
        chk("active_in_move", 32'(active), 1);

        // Player 2 acks first, player 1 three cycles later, collision ack two after that.
        move_ack = 2'b10; cyc();
        chk("p2_ack_drops_req", 32'(move_req), 2'b01);
        cyc();
        chk("p1_still_req", 32'(move_req), 2'b01);
        cyc();
        move_ack = 2'b01; cyc();
        chk("coll_req_t4", 32'({move_req, coll_req}), 3'b001);
        cyc();
        chk("coll_req_t5", 32'(coll_req), 1);
        coll_ack = 1'b1; cyc();
        exp_steps++;
        chk("coll_req_drop", 32'(coll_req), 0);
        chk("step_cnt_t6", 32'(step_cnt), 32'(exp_steps));
        chk("active_t6", 32'(active), 1);

        // Random ack orders and latencies over several steps.
        for (int s = 0; s < 8; s++) begin
            for (int f = 1; f <= int'(STEP_FRAMES_DEF); f++) begin
                idle($urandom_range(0, 2));
                frame();
                chk("rnd_step_issue", 32'(move_req), (f == int'(STEP_FRAMES_DEF)) ? 3 : 0);
            end
            d1 = $urandom_range(0, 5);
            d2 = $urandom_range(0, 5);
            acked = 2'b00;
            c = 0;
            while (acked != 2'b11 && c < 8) begin
                a = 2'b00;
                if (c == d1) a[0] = 1'b1;
                if (c == d2) a[1] = 1'b1;
                if (acked[0] && $urandom_range(0, 1) == 1) a[0] = 1'b1;
                move_ack = a;
                acked = acked | a;
                cyc();
                c++;
                if (acked != 2'b11) chk("rnd_move_req", 32'(move_req), 32'(2'(~acked)));
                else                chk("rnd_coll_rise", 32'({move_req, coll_req}), 3'b001);
            end
            dc = $urandom_range(0, 4);
            for (int i = 0; i < dc; i++) begin
                cyc();
                chk("rnd_coll_hold", 32'(coll_req), 1);
            end
            coll_ack = 1'b1; cyc();
            exp_steps++;
            chk("rnd_step_cnt", 32'(step_cnt), 32'(exp_steps));
            chk("rnd_coll_drop", 32'(coll_req), 0);
        end

        // Collision ack withheld: abort after ACK_TIMEOUT busy cycles.
        for (int f = 1; f <= int'(STEP_FRAMES_DEF); f++) frame();
        chk("to_step_issue", 32'(move_req), 3);
        move_ack = 2'b11; cyc();
        bad = 1'b0;
        for (int k = 2; k <= int'(ACK_TIMEOUT_DEF); k++) begin
            if (timeout_err || !coll_req) bad = 1'b1;
            cyc();
        end
        chk("to_no_early_abort", 32'(bad), 0);
        chk("to_pulse", 32'(timeout_err), 1);
        chk("to_coll_req", 32'({move_req, coll_req}), 0);
        chk("to_step_cnt_held", 32'(step_cnt), 32'(exp_steps));
        cyc();
        chk("to_pulse_one_cycle", 32'(timeout_err), 0);
        for (int f = 1; f <= int'(STEP_FRAMES_DEF); f++) begin
            idle($urandom_range(0, 2));
            frame();
            chk("to_next_step", 32'(move_req), (f == int'(STEP_FRAMES_DEF)) ? 3 : 0);
        end

        // Acks withheld across two step periods: overrun each time, one pending step.
        for (int f = 1; f <= 2 * int'(STEP_FRAMES_DEF); f++) begin
            idle($urandom_range(0, 2));
            frame();
            chk("ovr_pulse", 32'(overrun), (f % int'(STEP_FRAMES_DEF) == 0) ? 1 : 0);
        end
        cyc();
        chk("ovr_pulse_one_cycle", 32'(overrun), 0);
        chk("ovr_still_req", 32'(move_req), 3);
        move_ack = 2'b11; cyc();
        chk("ovr_coll", 32'(coll_req), 1);
        coll_ack = 1'b1; cyc();
        exp_steps++;
        chk("ovr_wait_gap", 32'({move_req, coll_req}), 0);
        chk("ovr_step_cnt", 32'(step_cnt), 32'(exp_steps));
        cyc();
        chk("ovr_reenter_move", 32'(move_req), 3);
        move_ack = 2'b11; cyc();
        coll_ack = 1'b1; cyc();
        exp_steps++;
        idle(3);
        chk("ovr_single_pending", 32'({move_req, coll_req}), 0);
        chk("ovr_step_cnt2", 32'(step_cnt), 32'(exp_steps));

        // Leaving GAME mid-move holds the score; re-entry restarts it.
        for (int f = 1; f <= int'(STEP_FRAMES_DEF); f++) frame();
        chk("exit_in_move", 32'(move_req), 3);
        mode = MODE_P1_WIN; cyc();
        chk("exit_reqs", 32'({move_req, coll_req}), 0);
        chk("exit_active", 32'(active), 0);
        chk("exit_countdown", 32'(countdown), 0);
        held = 16'(exp_steps);
        chk("exit_step_held", 32'(step_cnt), 32'(held));
        move_ack = 2'b11; coll_ack = 1'b1; cyc();
        frame();
        chk("late_ack_ignored", 32'({move_req, coll_req, active}), 0);
        chk("late_ack_step_held", 32'(step_cnt), 32'(held));
        mode = MODE_GAME; cyc();
        chk("reentry_step_cnt", 32'(step_cnt), 0);
        chk("reentry_countdown", 32'(countdown), COUNTDOWN_STEPS_DEF);

        // Reset in the middle of a countdown.
        frame();
        rst = 1'b1; cyc();
        chk("midop_rst_countdown", 32'(countdown), 0);
        chk("midop_rst_active", 32'(active), 0);
        rst = 1'b0; cyc();
        chk("post_rst_countdown", 32'(countdown), COUNTDOWN_STEPS_DEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
